// File: rtl/tc_pkg.sv
// Shared types and arithmetic helpers for the tensor-core merge tree.
package tc_pkg;

  localparam int unsigned DW_DATA_DEFAULT = 16;

  // Control bits that travel with each beat through the pipeline
  typedef struct packed {
    logic sat;
    logic acc;
  } beat_ctl_t;

  // Tree width: product width plus one bit per binary level plus one guard bit
  function automatic int unsigned tree_w(input int unsigned dw, input int unsigned tile_k);
    return dw + 32'($clog2(tile_k)) + 32'd1;
  endfunction

  // Largest value representable in dw signed bits
  function automatic logic signed [63:0] max_signed(input int unsigned dw);
    return (64'sd1 <<< (dw - 32'd1)) - 64'sd1;
  endfunction

  // Smallest value representable in dw signed bits
  function automatic logic signed [63:0] min_signed(input int unsigned dw);
    return -(64'sd1 <<< (dw - 32'd1));
  endfunction

  // True when v fits in dw signed bits
  function automatic logic fits_signed(input logic signed [63:0] v, input int unsigned dw);
    return (v >= min_signed(dw)) && (v <= max_signed(dw));
  endfunction

  // Clamp v into the dw-bit signed range
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int unsigned dw);
    logic signed [63:0] r;
    r = v;
    if (v > max_signed(dw)) r = max_signed(dw);
    if (v < min_signed(dw)) r = min_signed(dw);
    return r;
  endfunction

endpackage

// File: rtl/tc_addtree_stage.sv
// One registered binary-reduction level: N_IN operands in, N_IN/2 pairwise sums out.
module tc_addtree_stage #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned W      = 8,
  parameter int unsigned SIDE_W = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic [N_IN*W-1:0]         in_data,
  input  logic [SIDE_W-1:0]         in_side,
  output logic                      out_valid,
  output logic [(N_IN/2)*W-1:0]     out_data,
  output logic [SIDE_W-1:0]         out_side
);

  localparam int unsigned N_OUT = N_IN / 2;

  logic [N_OUT*W-1:0] sum_c;

  // Pairwise adds; W is sized by the caller so no level can overflow
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      sum_c[i*W +: W] = in_data[(2*i)*W +: W] + in_data[(2*i+1)*W +: W];
    end
  end

  // Stage register; bubbles advance with the data when enabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_side  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= sum_c;
      out_side  <= in_side;
    end
  end

endmodule

// File: rtl/tc_mergetree_pipe.sv
// Pipelined merge tree: reduces TILE_K products per lane, adds psum or the
// previous result, and converts to DW_DATA with wrap or saturation.
module tc_mergetree_pipe
  import tc_pkg::*;
#(
  parameter int unsigned N_MERGE = 16,
  parameter int unsigned TILE_K  = 4,
  parameter int unsigned DW_DATA = DW_DATA_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_MERGE*TILE_K*DW_DATA-1:0] in_mult,
  input  logic [N_MERGE*DW_DATA-1:0]    in_psum,
  input  logic                          in_acc,
  input  logic                          cfg_sat,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_MERGE*DW_DATA-1:0]    out,
  output logic [N_MERGE-1:0]            out_ovf
);

  localparam int unsigned N_UNIT     = N_MERGE * TILE_K;
  localparam int unsigned LAT        = 32'($clog2(TILE_K)) + 32'd1;
  localparam int unsigned N_TREE_LVL = LAT - 32'd1;
  localparam int unsigned TW         = tree_w(DW_DATA, TILE_K);
  localparam int unsigned FW         = TW + 32'd1;
  localparam int unsigned CTL_W      = $bits(beat_ctl_t);
  localparam int unsigned SIDE_W     = N_MERGE * DW_DATA + CTL_W;

  logic      en_c;
  logic      accept_c;
  beat_ctl_t ctl_in;

  assign en_c     = !out_valid || out_ready;
  assign in_ready = en_c;
  assign accept_c = in_valid && en_c;
  assign ctl_in.sat = cfg_sat;
  assign ctl_in.acc = in_acc;

  // Level 0 is the sign-extended input; each further level is one registered tree stage
  for (genvar i = 0; i <= N_TREE_LVL; i++) begin : g_lvl
    localparam int unsigned N = N_UNIT >> i;
    logic [N*TW-1:0]   d;
    logic              v;
    logic [SIDE_W-1:0] s;
    if (i == 0) begin : g_src
      for (genvar u = 0; u < N_UNIT; u++) begin : g_ext
        assign d[u*TW +: TW] = TW'($signed(in_mult[u*DW_DATA +: DW_DATA]));
      end
      assign v = accept_c;
      assign s = {ctl_in, in_psum};
    end else begin : g_stg
      tc_addtree_stage #(
        .N_IN   (2 * N),
        .W      (TW),
        .SIDE_W (SIDE_W)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .en        (en_c),
        .in_valid  (g_lvl[i-1].v),
        .in_data   (g_lvl[i-1].d),
        .in_side   (g_lvl[i-1].s),
        .out_valid (v),
        .out_data  (d),
        .out_side  (s)
      );
    end
  end

  logic                       vf;
  logic [N_MERGE*TW-1:0]      sf;
  logic [SIDE_W-1:0]          side_f;
  logic [N_MERGE*DW_DATA-1:0] psum_f;
  beat_ctl_t                  ctl_f;

  assign vf     = g_lvl[N_TREE_LVL].v;
  assign sf     = g_lvl[N_TREE_LVL].d;
  assign side_f = g_lvl[N_TREE_LVL].s;
  assign psum_f = side_f[N_MERGE*DW_DATA-1:0];
  assign ctl_f  = beat_ctl_t'(side_f[SIDE_W-1 -: CTL_W]);

  logic [N_MERGE*DW_DATA-1:0] nxt_out;
  logic [N_MERGE-1:0]         nxt_ovf;
  logic signed [TW-1:0]       tsum;
  logic signed [FW-1:0]       opnd;
  logic signed [FW-1:0]       full;

  // Final add at full width, then overflow detect and wrap/saturate conversion
  always_comb begin
    nxt_out = out;
    nxt_ovf = out_ovf;
    tsum    = '0;
    opnd    = '0;
    full    = '0;
    for (int unsigned j = 0; j < N_MERGE; j++) begin
      tsum = $signed(sf[j*TW +: TW]);
      if (ctl_f.acc) opnd = FW'($signed(out[j*DW_DATA +: DW_DATA]));
      else           opnd = FW'($signed(psum_f[j*DW_DATA +: DW_DATA]));
      full = FW'(tsum) + opnd;
      nxt_ovf[j] = !fits_signed(64'(full), DW_DATA);
      if (ctl_f.sat) nxt_out[j*DW_DATA +: DW_DATA] = DW_DATA'(sat_signed(64'(full), DW_DATA));
      else           nxt_out[j*DW_DATA +: DW_DATA] = DW_DATA'(full);
    end
  end

  // Output register; holds its value across bubbles so accumulate chains survive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_ovf   <= '0;
    end else if (en_c) begin
      out_valid <= vf;
      if (vf) begin
        out     <= nxt_out;
        out_ovf <= nxt_ovf;
      end
    end
  end

endmodule

// File: doc/tc_mergetree_pipe.md
Name: tc_mergetree_pipe

Overview:
Pipelined, parametrised successor to the tensor-core merge tree. Reduces N_MERGE groups of TILE_K signed multiplier products into N_MERGE partial sums and adds each sum to a partial-sum operand. That operand is either an external psum or the block's own previous result (accumulate mode). Sits between the multiplier array and the output/psum buffer, with a valid/ready handshake on both sides, backpressure support, and selectable wrap or saturating output.

Parameters:
N_MERGE, 16, number of output lanes (merge groups)
TILE_K, 4, products reduced per lane; power of two, >=1
DW_DATA, 16, width of each product, psum and output element (two's complement)
N_UNIT, N_MERGE*TILE_K, localparam: number of product lanes
LAT, $clog2(TILE_K)+1, localparam: pipeline depth in accepted-beat cycles

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
in_valid  in  1  input beat valid
in_ready  out  1  block can accept beat this cycle
in_mult  in  N_UNIT*DW_DATA  products; lane u at bits [u*DW_DATA +: DW_DATA]
in_psum  in  N_MERGE*DW_DATA  external partial sums; lane j at [j*DW_DATA +: DW_DATA]
in_acc  in  1  1: add tree sum to previous output instead of in_psum
cfg_sat  in  1  1: saturate on overflow; 0: wrap; sampled with the beat
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts output
out  out  N_MERGE*DW_DATA  results, lane j at [j*DW_DATA +: DW_DATA]
out_ovf  out  N_MERGE  per-lane overflow flag for the current output beat

Behaviour:
- Reset (reset==0, async): all stage valid bits, out, out_ovf and out_valid go to 0; in_ready goes to 1 after reset release. Reset mid-stream discards all in-flight beats, no partial output.
- Lane mapping: out lane j = sum over k=0..TILE_K-1 of in_mult lane j*TILE_K+k, plus operand P.
- Arithmetic: all values signed. Tree adds are sign-extended to DW_DATA+$clog2(TILE_K)+1 bits, so the tree never overflows internally. Final sum = tree + P, computed at full width.
- Operand P: in_psum if in_acc==0. If in_acc==1, P is the out register value at the time the beat enters the final stage, which is the immediately preceding beat's result, whether or not that result has already been consumed. in_psum is ignored when in_acc==1. After reset, the acc value is 0.
- Output conversion: cfg_sat==1 clamps to [-2^(DW_DATA-1), 2^(DW_DATA-1)-1]. cfg_sat==0 keeps the low DW_DATA bits. In both modes out_ovf[j]=1 iff the full sum does not fit in DW_DATA signed bits.
- Pipeline: $clog2(TILE_K) tree stages (one binary level each), then one final add/convert stage that drives out. in_psum, in_acc and cfg_sat travel with the beat.
- Latency: a beat accepted at edge t appears on out with out_valid=1 after edge t+LAT-1, provided there is no stall. TILE_K=1 gives LAT=1: the tree is empty and only the final stage remains.
- Stall: en = !out_valid || out_ready. When en==1, all stages advance together; bubbles are carried, not collapsed. When en==0, every stage register holds, out and out_ovf are stable, and in_ready=0.
- in_ready = en, combinational from out_ready. Accept = in_valid && in_ready.
- Simultaneous out_ready and a new accept in the same cycle: full throughput, one beat per cycle.
- out_valid drops to 0 when the final stage receives a bubble while en==1. out holds its last value so accumulate chains survive bubbles.

Decomposition:
- Shared package tc_pkg: DW_DATA default, a function computing the tree width, and saturate/overflow-detect helper functions.
- Sub-module tc_addtree_stage: one registered binary-reduction level. Parametrised on input count and width, with an en input. It is instantiated $clog2(TILE_K) times by a generate loop; the final psum/convert stage stays in the top.

Test Plan:
1. Default params. in_mult lane u = u%16, in_psum all 1, in_acc=0, out_ready=1 -> after LAT=3 cycles, out lanes j%4 = 0,1,2,3 give 7,23,39,55, repeating for all 16 lanes; out_ovf=0; out_valid high for exactly 1 cycle.
2. Backpressure. Stream 4 beats; drop out_ready for 5 cycles while beat 1 is at the output -> out and out_ovf held, in_ready=0; no beat lost or duplicated; order preserved after release.
3. Overflow. All products 16'h7FFF, psum 16'h7FFF. cfg_sat=1 -> out 16'h7FFF, out_ovf all 1. cfg_sat=0 -> out = low 16 bits of 5*32767, which is 16'h7FFB, out_ovf all 1.
4. Accumulate chain. Beat A: in_acc=0, psum 10, products all 1 -> 14. Beat B back-to-back: in_acc=1, products all 2 -> 22. Beat C after a 3-cycle bubble: in_acc=1, products all 1 -> 26.
5. Reset mid-stream. Assert reset with 2 beats in flight -> out=0 and out_valid=0 immediately. After release, a single in_acc=1 beat with products all 1 -> 4, showing the acc value cleared to 0.
6. Param sweep. TILE_K=1, LAT=1: out = in_mult + in_psum one cycle after accept. TILE_K=8, N_MERGE=4, LAT=4: random signed vectors match the reference model every cycle under random out_ready.
